regfile_wport_arbiter: RTL and testbench

//  Shares the single RegFile write port between the in-order pipeline write-back (MEM/WB) and the

---
 rtl/regfile_wport_arbiter_pkg.sv | 15 +
 rtl/regwr_fifo.sv | 125 ++++++++++++
 rtl/regfile_wport_arbiter.sv | 172 +++++++++++++++++
 tb/tb_regfile_wport_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared types and constants for the RegFile write-port arbiter.
// Reset level, register bus widths and the arbiter FSM states.
package regfile_wport_arbiter_pkg;

  localparam logic RST_ENABLE = 1'b0;
  localparam int   REG_AW     = 5;
  localparam int   REG_DW     = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_FORCE
  } arb_state_t;

endpackage

// File: rtl/regwr_fifo.sv
// Circular queue of pending MDU results: addr, data and a kill bit
// per entry; wrap-around pointers plus count.
// Ports: i_push/i_pop enqueue/dequeue; i_kill_en/i_kill_addr mark
// matching live entries dead; i_raddr1/2 look up live entries
// (o_hit1/2); o_head_* present the oldest entry; o_empty/o_full/o_last
// report occupancy. REGARB_FWD_EN adds o_fwd_data1/2 (youngest match).
module regwr_fifo
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [REG_AW-1:0] i_push_addr,
  input  logic [REG_DW-1:0] i_push_data,
  input  logic              i_pop,
  input  logic              i_kill_en,
  input  logic [REG_AW-1:0] i_kill_addr,
  input  logic [REG_AW-1:0] i_raddr1,
  input  logic [REG_AW-1:0] i_raddr2,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_last,
  output logic [REG_AW-1:0] o_head_addr,
  output logic [REG_DW-1:0] o_head_data,
  output logic              o_head_kill,
`ifdef REGARB_FWD_EN
  output logic [REG_DW-1:0] o_fwd_data1,
  output logic [REG_DW-1:0] o_fwd_data2,
`endif
  output logic              o_hit1,
  output logic              o_hit2
);

  localparam int AW = $clog2(DEPTH);

  logic [REG_AW-1:0] r_addr [DEPTH];
  logic [REG_DW-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_kill;
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_cnt;

  logic [DEPTH-1:0]  w_occ;
  logic [DEPTH-1:0]  w_kmatch;
  logic [DEPTH-1:0]  w_live1;
  logic [DEPTH-1:0]  w_live2;
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_last  = (r_cnt == (AW+1)'(1));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  assign o_head_addr = r_addr[r_rptr];
  assign o_head_data = r_data[r_rptr];
  assign o_head_kill = r_kill[r_rptr];

  // Per-entry compares; occupancy is the entry's age below count.
  always_comb begin
    w_occ    = '0;
    w_kmatch = '0;
    w_live1  = '0;
    w_live2  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ[i] = {1'b0, AW'(AW'(i) - r_rptr)} < r_cnt;
      w_kmatch[i] = w_occ[i] && (r_addr[i] == i_kill_addr);
      w_live1[i] = w_occ[i] && !r_kill[i]
                   && (r_addr[i] == i_raddr1);
      w_live2[i] = w_occ[i] && !r_kill[i]
                   && (r_addr[i] == i_raddr2);
    end
  end

  assign o_hit1 = |w_live1;
  assign o_hit2 = |w_live2;

`ifdef REGARB_FWD_EN
  // Walk oldest to youngest so the last match wins.
  always_comb begin
    o_fwd_data1 = '0;
    o_fwd_data2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_live1[AW'(r_rptr + AW'(k))])
        o_fwd_data1 = r_data[AW'(r_rptr + AW'(k))];
      if (w_live2[AW'(r_rptr + AW'(k))])
        o_fwd_data2 = r_data[AW'(r_rptr + AW'(k))];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_kill <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (i_kill_en)
        r_kill <= r_kill | w_kmatch;
      // Slot being pushed is never occupied, so it stays unkilled.
      if (w_push) begin
        r_addr[r_wptr] <= i_push_addr;
        r_data[r_wptr] <= i_push_data;
        r_kill[r_wptr] <= 1'b0;
        r_wptr         <= r_wptr + AW'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Shares the RegFile write port between MEM/WB (always wins) and queued
// MDU results; starved results raise stall_req. Optional: REGARB_FWD_EN.
// Ports: pipe_* MEM/WB write; mdu_* MDU result in + mdu_ready;
// wb_* registered RegFile write; id_re/id_raddr 1/2 in, hazard1/2 out;
// stall_req registered freeze request; fwd_valid/fwd_data 1/2 with FWD.
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  input  logic        id_re1,
  input  logic        id_re2,
  input  logic [4:0]  id_raddr1,
  input  logic [4:0]  id_raddr2,
`ifdef REGARB_FWD_EN
  output logic        fwd_valid1,
  output logic        fwd_valid2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2,
`endif
  output logic        hazard1,
  output logic        hazard2,
  output logic        stall_req
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  arb_state_t  r_state;
  arb_state_t  w_state_next;
  logic [WW-1:0] r_wait;
  logic        r_stall;
  logic        r_wb_we;
  logic [4:0]  r_wb_addr;
  logic [31:0] r_wb_data;

  logic        w_empty;
  logic        w_full;
  logic        w_last;
  logic [4:0]  w_head_addr;
  logic [31:0] w_head_data;
  logic        w_head_kill;
  logic        w_hit1;
  logic        w_hit2;
  logic        w_grant;
  logic        w_push;
  logic        w_pop;
  logic        w_rd1;
  logic        w_rd2;
`ifdef REGARB_FWD_EN
  logic [31:0] w_fwd1;
  logic [31:0] w_fwd2;
`endif

  // A write to r0 is a no-op, so it leaves the slot free.
  assign w_grant   = pipe_we && (pipe_addr != '0);
  assign mdu_ready = !w_full;
  // r0 results are accepted but never enter the queue.
  assign w_push    = mdu_valid && !w_full && (mdu_addr != '0);
  assign w_pop     = !w_grant && !w_empty;
  assign w_rd1     = id_re1 && (id_raddr1 != '0);
  assign w_rd2     = id_re2 && (id_raddr2 != '0);

  regwr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_addr (mdu_addr),
    .i_push_data (mdu_data),
    .i_pop       (w_pop),
    .i_kill_en   (w_grant),
    .i_kill_addr (pipe_addr),
    .i_raddr1    (id_raddr1),
    .i_raddr2    (id_raddr2),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_last      (w_last),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_head_kill (w_head_kill),
`ifdef REGARB_FWD_EN
    .o_fwd_data1 (w_fwd1),
    .o_fwd_data2 (w_fwd2),
`endif
    .o_hit1      (w_hit1),
    .o_hit2      (w_hit2)
  );

`ifdef REGARB_FWD_EN
  assign fwd_valid1 = w_rd1 && w_hit1;
  assign fwd_valid2 = w_rd2 && w_hit2;
  assign fwd_data1  = w_fwd1;
  assign fwd_data2  = w_fwd2;
  assign hazard1    = 1'b0;
  assign hazard2    = 1'b0;
`else
  assign hazard1    = w_rd1 && w_hit1;
  assign hazard2    = w_rd2 && w_hit2;
`endif

  assign wb_we     = r_wb_we;
  assign wb_addr   = r_wb_addr;
  assign wb_data   = r_wb_data;
  assign stall_req = r_stall;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_push)
          w_state_next = ST_PEND;
      end
      ST_PEND: begin
        if (r_wait == WW'(MAX_WAIT))
          w_state_next = ST_FORCE;
        else if (w_pop && w_last && !w_push)
          w_state_next = ST_IDLE;
      end
      ST_FORCE: begin
        if (w_empty && !w_push)
          w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state   <= ST_IDLE;
      r_wait    <= '0;
      r_stall   <= 1'b0;
      r_wb_we   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      r_state <= w_state_next;
      r_stall <= (w_state_next == ST_FORCE);
      if (w_empty || w_pop)
        r_wait <= '0;
      else if (r_wait != WW'(MAX_WAIT))
        r_wait <= r_wait + WW'(1);
      if (w_grant) begin
        r_wb_we   <= 1'b1;
        r_wb_addr <= pipe_addr;
        r_wb_data <= pipe_data;
      end else if (w_pop && !w_head_kill) begin
        r_wb_we   <= 1'b1;
        r_wb_addr <= w_head_addr;
        r_wb_data <= w_head_data;
      end else begin
        r_wb_we   <= 1'b0;
        r_wb_addr <= '0;
        r_wb_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter: reset, MDU drain, starvation
// stall, full queue, kill ordering, hazard/forward lookup, mid-run reset.
module tb_regfile_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        id_re1;
  logic        id_re2;
  logic [4:0]  id_raddr1;
  logic [4:0]  id_raddr2;
  logic        hazard1;
  logic        hazard2;
  logic        stall_req;
`ifdef REGARB_FWD_EN
  logic        fwd_valid1;
  logic        fwd_valid2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_wport_arbiter #(
    .FIFO_DEPTH (2),
    .MAX_WAIT   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_we    (pipe_we),
    .pipe_addr  (pipe_addr),
    .pipe_data  (pipe_data),
    .mdu_valid  (mdu_valid),
    .mdu_ready  (mdu_ready),
    .mdu_addr   (mdu_addr),
    .mdu_data   (mdu_data),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .id_re1     (id_re1),
    .id_re2     (id_re2),
    .id_raddr1  (id_raddr1),
    .id_raddr2  (id_raddr2),
`ifdef REGARB_FWD_EN
    .fwd_valid1 (fwd_valid1),
    .fwd_valid2 (fwd_valid2),
    .fwd_data1  (fwd_data1),
    .fwd_data2  (fwd_data2),
`endif
    .hazard1    (hazard1),
    .hazard2    (hazard2),
    .stall_req  (stall_req)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    pipe_we = 1'b0; pipe_addr = '0; pipe_data = '0;
    mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0;
    id_re1 = 1'b0; id_re2 = 1'b0; id_raddr1 = '0; id_raddr2 = '0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();

    // reset / idle state
    check("rst_wb_we", 32'(wb_we), 32'd0);
    check("rst_wb_addr", 32'(wb_addr), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_ready", 32'(mdu_ready), 32'd1);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_haz1", 32'(hazard1), 32'd0);
    check("rst_haz2", 32'(hazard2), 32'd0);

    // single MDU result drains into an idle slot
    mdu_valid = 1'b1; mdu_addr = 5'd5; mdu_data = 32'hA5;
    tick();
    mdu_valid = 1'b0;
    id_re1 = 1'b1; id_raddr1 = 5'd5;
    #1;
`ifdef REGARB_FWD_EN
    check("r5_fwdv", 32'(fwd_valid1), 32'd1);
    check("r5_fwdd", fwd_data1, 32'hA5);
    check("r5_haz0", 32'(hazard1), 32'd0);
`else
    check("r5_haz", 32'(hazard1), 32'd1);
`endif
    check("r5_nowr", 32'(wb_we), 32'd0);
    tick();
    check("r5_we", 32'(wb_we), 32'd1);
    check("r5_addr", 32'(wb_addr), 32'd5);
    check("r5_data", wb_data, 32'hA5);
`ifdef REGARB_FWD_EN
    check("r5_fwd_gone", 32'(fwd_valid1), 32'd0);
`else
    check("r5_haz_gone", 32'(hazard1), 32'd0);
`endif
    id_re1 = 1'b0;
    tick();
    check("r5_after", 32'(wb_we), 32'd0);

    // starvation: pipe r1..r6, MDU r7 queued at cycle 0
    pipe_we = 1'b1; pipe_addr = 5'd1; pipe_data = 32'h101;
    mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'h77;
    tick();
    mdu_valid = 1'b0;
    for (int i = 2; i <= 6; i++) begin
      pipe_addr = 5'(i);
      pipe_data = 32'h100 + 32'(i);
      check("stall_early", 32'(stall_req), 32'd0);
      tick();
    end
    check("stall_rise", 32'(stall_req), 32'd1);
    check("stall_pipe_addr", 32'(wb_addr), 32'd6);
    pipe_we = 1'b0;
    tick();
    check("r7_we", 32'(wb_we), 32'd1);
    check("r7_addr", 32'(wb_addr), 32'd7);
    check("r7_data", wb_data, 32'h77);
    check("stall_hold", 32'(stall_req), 32'd1);
    tick();
    check("stall_fall", 32'(stall_req), 32'd0);
    check("r7_done", 32'(wb_we), 32'd0);

    // full queue back-pressure
    pipe_we = 1'b1; pipe_addr = 5'd20; pipe_data = 32'h200;
    mdu_valid = 1'b1; mdu_addr = 5'd3; mdu_data = 32'h33;
    tick();
    check("full_ready1", 32'(mdu_ready), 32'd1);
    pipe_addr = 5'd21;
    mdu_addr = 5'd4; mdu_data = 32'h44;
    tick();
    check("full_ready0", 32'(mdu_ready), 32'd0);
    pipe_addr = 5'd22;
    mdu_addr = 5'd10; mdu_data = 32'hAA;
    tick();
    check("full_ready0b", 32'(mdu_ready), 32'd0);
    pipe_we = 1'b0;
    tick();
    check("full_pop_r3", 32'(wb_addr), 32'd3);
    check("full_pop_d3", wb_data, 32'h33);
    check("full_ready_back", 32'(mdu_ready), 32'd1);
    tick();
    mdu_valid = 1'b0;
    check("full_pop_r4", 32'(wb_addr), 32'd4);
    check("full_pop_d4", wb_data, 32'h44);
    tick();
    check("full_r10_we", 32'(wb_we), 32'd1);
    check("full_r10_addr", 32'(wb_addr), 32'd10);
    check("full_r10_data", wb_data, 32'hAA);
    tick();
    check("full_no_dup", 32'(wb_we), 32'd0);

    // younger pipe write kills queued r9
    mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'h11;
    tick();
    mdu_valid = 1'b0;
    pipe_we = 1'b1; pipe_addr = 5'd9; pipe_data = 32'h22;
    id_re2 = 1'b1; id_raddr2 = 5'd9;
    #1;
`ifdef REGARB_FWD_EN
    check("kill_fwd_pre", 32'(fwd_valid2), 32'd1);
    check("kill_fwdd_pre", fwd_data2, 32'h11);
`else
    check("kill_haz_pre", 32'(hazard2), 32'd1);
`endif
    tick();
    pipe_we = 1'b0;
    #1;
    check("kill_pipe_we", 32'(wb_we), 32'd1);
    check("kill_pipe_data", wb_data, 32'h22);
`ifdef REGARB_FWD_EN
    check("kill_fwd_post", 32'(fwd_valid2), 32'd0);
`else
    check("kill_haz_post", 32'(hazard2), 32'd0);
`endif
    tick();
    check("kill_pop_we", 32'(wb_we), 32'd0);
    id_re2 = 1'b0;

    // r0 MDU result is discarded
    mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 32'hDEAD;
    tick();
    mdu_valid = 1'b0;
    tick();
    check("r0_discard", 32'(wb_we), 32'd0);
    check("r0_ready", 32'(mdu_ready), 32'd1);

    // hazard on queued r8; pipe r0 write is a free slot
    pipe_we = 1'b1; pipe_addr = 5'd30; pipe_data = 32'h300;
    mdu_valid = 1'b1; mdu_addr = 5'd8; mdu_data = 32'h88;
    tick();
    mdu_valid = 1'b0;
    pipe_addr = 5'd31; pipe_data = 32'h310;
    id_re1 = 1'b1; id_raddr1 = 5'd8;
    id_re2 = 1'b0; id_raddr2 = 5'd8;
    #1;
`ifdef REGARB_FWD_EN
    check("r8_fwdv", 32'(fwd_valid1), 32'd1);
    check("r8_fwdd", fwd_data1, 32'h88);
    check("r8_haz_tied", 32'(hazard1), 32'd0);
    check("r8_fwdv2_re0", 32'(fwd_valid2), 32'd0);
`else
    check("r8_haz1", 32'(hazard1), 32'd1);
    check("r8_haz2_re0", 32'(hazard2), 32'd0);
`endif
    tick();
    check("r8_pipe31", 32'(wb_addr), 32'd31);
    pipe_addr = 5'd0; pipe_data = 32'hBAD;
    tick();
    check("r8_we", 32'(wb_we), 32'd1);
    check("r8_addr", 32'(wb_addr), 32'd8);
    check("r8_data", wb_data, 32'h88);
    pipe_we = 1'b0;
    id_re1 = 1'b0;
    tick();
    check("r8_idle_we", 32'(wb_we), 32'd0);
    check("r8_idle_stall", 32'(stall_req), 32'd0);

    // reset mid-operation flushes the queue
    pipe_we = 1'b1; pipe_addr = 5'd1; pipe_data = 32'h1;
    mdu_valid = 1'b1; mdu_addr = 5'd12; mdu_data = 32'hC;
    tick();
    mdu_valid = 1'b0;
    pipe_we = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mrst_we", 32'(wb_we), 32'd0);
    tick();
    check("mrst_flush", 32'(wb_we), 32'd0);
    tick();
    check("mrst_flush2", 32'(wb_we), 32'd0);
    check("mrst_ready", 32'(mdu_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
